// File: rtl/mod3_pkg.sv
// mod3_pkg: shared types and the residue-to-check-bits mapping for the mod-3 framed serial transmitter.
`default_nettype none

package mod3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK1 = 2'd2,
    CHK0 = 2'd3
  } state_t;

  typedef logic [1:0] residue_t;

  // Check bits c[1:0] = (3 - rem) mod 3, so that {payload, c} is a multiple of 3.
  function automatic logic [1:0] chk_bits(input residue_t rem);
    logic [1:0] c;
    case (rem)
      2'd1:    c = 2'b10;
      2'd2:    c = 2'b01;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod3_residue_step.sv
// mod3_residue_step: next running residue (2*rem + bit) mod 3 for an MSB-first bit stream.
`default_nettype none

module mod3_residue_step
  import mod3_pkg::*;
(
  input  residue_t rem_i,
  input  logic     bit_i,
  output residue_t rem_o
);

  always_comb begin
    rem_o = 2'd0;
    case ({rem_i, bit_i})
      3'b00_0: rem_o = 2'd0;
      3'b00_1: rem_o = 2'd1;
      3'b01_0: rem_o = 2'd2;
      3'b01_1: rem_o = 2'd0;
      3'b10_0: rem_o = 2'd1;
      3'b10_1: rem_o = 2'd2;
      default: rem_o = 2'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mod3_serial_tx.sv
// mod3_serial_tx: serialises a DATA_W-bit payload MSB-first and appends two check bits
// so that every DATA_W+2 bit frame, read as an unsigned number, is divisible by 3.
`default_nettype none

module mod3_serial_tx
  import mod3_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_bit,
  output logic              o_bit_valid,
  input  logic              i_bit_ready,
  output logic              o_sof,
  output logic              o_eof
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  residue_t          rem_q;
  residue_t          rem_d;
  logic [1:0]        chk_q;
  logic              bit_d;
  logic              active;
  logic              ready_int;
  logic              bit_hs;
  logic              accept;

  assign active    = (state_q != IDLE);
  assign ready_int = (state_q == IDLE) || ((state_q == CHK0) && i_bit_ready);
  assign bit_hs    = active && i_bit_ready;
  assign accept    = i_valid && ready_int;

  mod3_residue_step u_step (
    .rem_i (rem_q),
    .bit_i (shift_q[DATA_W-1]),
    .rem_o (rem_d)
  );

  always_comb begin
    bit_d = 1'b0;
    case (state_q)
      DATA:    bit_d = shift_q[DATA_W-1];
      CHK1:    bit_d = chk_q[1];
      CHK0:    bit_d = chk_q[0];
      default: bit_d = 1'b0;
    endcase
  end

  // Outputs are decoded from registered state and forced low while reset is held.
  assign o_ready     = i_rst_n && ready_int;
  assign o_bit       = i_rst_n && bit_d;
  assign o_bit_valid = i_rst_n && active;
  assign o_sof       = i_rst_n && (state_q == DATA) && (cnt_q == '0);
  assign o_eof       = i_rst_n && (state_q == CHK0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      rem_q   <= 2'd0;
      chk_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= i_data;
            cnt_q   <= '0;
            rem_q   <= 2'd0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_hs) begin
            shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            rem_q   <= rem_d;
            if (cnt_q == CNT_LAST) begin
              chk_q   <= chk_bits(rem_d);
              cnt_q   <= '0;
              state_q <= CHK1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        CHK1: begin
          if (bit_hs) state_q <= CHK0;
        end
        CHK0: begin
          // Accepting here implies the final check bit is handshaked this cycle.
          if (accept) begin
            shift_q <= i_data;
            cnt_q   <= '0;
            rem_q   <= 2'd0;
            state_q <= DATA;
          end else if (bit_hs) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mod3_serial_tx.sv
// tb_mod3_serial_tx: table-driven and randomized checks of mod3_serial_tx against an arithmetic frame model.
module tb_mod3_serial_tx;

  logic       clk;
  logic       i_rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_bit;
  logic       o_bit_valid;
  logic       i_bit_ready;
  logic       o_sof;
  logic       o_eof;

  int n_vec;
  int n_miss;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_bits;
    int         mode;
  } vec_t;

  vec_t vecs[8];

  mod3_serial_tx #(.DATA_W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_bit       (o_bit),
    .o_bit_valid (o_bit_valid),
    .i_bit_ready (i_bit_ready),
    .o_sof       (o_sof),
    .o_eof       (o_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int r;
    int c;
    r = int'(d) % 3;
    c = (3 - r) % 3;
    return 10'(int'(d) * 4 + c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start(input logic [7:0] d, output logic got);
    got = 1'b0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data = d;
    i_bit_ready = 1'b1;
    #1;
    for (int k = 0; k < 50; k++) begin
      if (o_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  // Collects one frame starting the cycle after its accept; checks flag, hold and ready behaviour.
  task automatic collect(input int mode, input logic nv, input logic [7:0] nd,
                         output logic [9:0] bits, output logic ok);
    int idx;
    int held;
    logic pstall, pb, ps, pe;
    bits = '0; ok = 1'b1; idx = 0; held = 0;
    pstall = 1'b0; pb = 1'b0; ps = 1'b0; pe = 1'b0;
    for (int cyc = 0; cyc < 200 && idx < 10; cyc++) begin
      @(negedge clk);
      i_valid = nv;
      i_data = nv ? nd : 8'($urandom);
      case (mode)
        1:       i_bit_ready = ($urandom_range(0, 2) != 0);
        2:       i_bit_ready = !(idx == 4 && held < 3);
        default: i_bit_ready = 1'b1;
      endcase
      if (mode == 2 && !i_bit_ready) held++;
      #1;
      if (cyc == 0 && !(o_bit_valid && o_sof)) ok = 1'b0;
      if (!o_bit_valid) ok = 1'b0;
      if (o_sof !== (idx == 0)) ok = 1'b0;
      if (o_eof !== (idx == 9)) ok = 1'b0;
      if (o_ready !== ((idx == 9) && i_bit_ready)) ok = 1'b0;
      if (pstall && ({o_bit, o_sof, o_eof} !== {pb, ps, pe})) ok = 1'b0;
      if (i_bit_ready) begin
        bits[9-idx] = o_bit;
        idx++;
        pstall = 1'b0;
      end else begin
        pstall = 1'b1;
        pb = o_bit; ps = o_sof; pe = o_eof;
      end
    end
    if (idx < 10) ok = 1'b0;
    if (mode == 2 && held != 3) ok = 1'b0;
  endtask

  initial begin
    logic       got;
    logic       ok;
    logic [9:0] bits;
    logic [7:0] d, d2;

    n_vec = 0;
    n_miss = 0;
    vecs[0] = '{8'h06, 10'b0000011000, 0};
    vecs[1] = '{8'h07, 10'b0000011110, 0};
    vecs[2] = '{8'h05, 10'b0000010101, 0};
    vecs[3] = '{8'hFF, 10'b1111111100, 0};
    vecs[4] = '{8'h00, 10'b0000000000, 0};
    vecs[5] = '{8'h01, 10'b0000000110, 0};
    vecs[6] = '{8'h80, 10'b1000000001, 0};
    vecs[7] = '{8'h06, 10'b0000011000, 2};

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data = 8'hA5;
    i_bit_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_outputs", {27'd0, o_ready, o_bit, o_bit_valid, o_sof, o_eof}, 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    check("post_reset_idle", {30'd0, o_ready, o_bit_valid}, 32'b10);

    for (int v = 0; v < 8; v++) begin
      start(vecs[v].data, got);
      check($sformatf("accept_%0d", v), 32'(got), 32'd1);
      collect(vecs[v].mode, 1'b0, 8'h00, bits, ok);
      check($sformatf("frame_%0d", v), 32'(bits), 32'(vecs[v].exp_bits));
      check($sformatf("flags_%0d", v), 32'(ok), 32'd1);
    end

    // Back-to-back: valid held high, second payload taken on the CHK0 handshake.
    start(8'h07, got);
    check("b2b_accept", 32'(got), 32'd1);
    collect(0, 1'b1, 8'h05, bits, ok);
    check("b2b_frame_a", 32'(bits), 32'(10'b0000011110));
    check("b2b_flags_a", 32'(ok), 32'd1);
    collect(0, 1'b0, 8'h00, bits, ok);
    check("b2b_frame_b", 32'(bits), 32'(10'b0000010101));
    check("b2b_flags_b", 32'(ok), 32'd1);

    // Reset mid-frame.
    start(8'hA5, got);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_bit_ready = 1'b1;
    end
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    check("midreset_outputs", {27'd0, o_ready, o_bit, o_bit_valid, o_sof, o_eof}, 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    check("midreset_release", {30'd0, o_ready, o_bit_valid}, 32'b10);
    start(8'h07, got);
    collect(0, 1'b0, 8'h00, bits, ok);
    check("midreset_frame", 32'(bits), 32'(10'b0000011110));
    check("midreset_flags", 32'(ok), 32'd1);

    // Randomized frames with random sink stalls, some back-to-back.
    for (int r = 0; r < 24; r++) begin
      d = 8'($urandom);
      d2 = 8'($urandom);
      start(d, got);
      check("rand_accept", 32'(got), 32'd1);
      if (r % 4 == 3) begin
        collect(1, 1'b1, d2, bits, ok);
        check("rand_frame", 32'(bits), 32'(model_frame(d)));
        check("rand_flags", 32'(ok), 32'd1);
        collect(1, 1'b0, 8'h00, bits, ok);
        check("rand_frame_b2b", 32'(bits), 32'(model_frame(d2)));
        check("rand_flags_b2b", 32'(ok), 32'd1);
      end else begin
        collect(1, 1'b0, 8'h00, bits, ok);
        check("rand_frame", 32'(bits), 32'(model_frame(d)));
        check("rand_flags", 32'(ok), 32'd1);
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        i_valid = 1'b0;
        i_data = 8'($urandom);
        #1;
        check("idle_state", {30'd0, o_ready, o_bit_valid}, 32'b10);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mod3_serial_tx.md
MOD3_SERIAL_TX -- requirements
Module: mod3_serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (DATA_W >= 2).
REQ-002 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-004 SHALL have port i_data  input  DATA_W  parallel payload, sampled on accept.
REQ-005 SHALL have port i_valid  input  1  payload offered.
REQ-006 SHALL have port o_ready  output  1  payload can be accepted this cycle.
REQ-007 SHALL have port o_bit  output  1  serial frame bit, MSB-first.
REQ-008 SHALL have port o_bit_valid  output  1  o_bit is valid.
REQ-009 SHALL have port i_bit_ready  input  1  sink accepts o_bit this cycle.
REQ-010 SHALL have port o_sof  output  1  o_bit is first bit of frame.
REQ-011 SHALL have port o_eof  output  1  o_bit is last bit of frame.

Function
REQ-012 SHALL emit frames of DATA_W+2 bits: payload MSB-first, then 2 check bits c[1],c[0], so the frame read as an unsigned binary number is divisible by 3.
REQ-013 SHALL use FSM states IDLE, DATA, CHK1, CHK0; IDLE->DATA on accept; DATA->CHK1 on handshake of payload bit 0; CHK1->CHK0 on handshake; CHK0->IDLE on handshake with no new accept, CHK0->DATA on handshake with simultaneous accept.
REQ-014 Accept SHALL be i_valid && o_ready; o_ready SHALL be 1 in IDLE, or in CHK0 when i_bit_ready=1, otherwise 0.
REQ-015 First payload bit SHALL appear on o_bit with o_bit_valid=1 and o_sof=1 the cycle after accept (latency 1), with no idle cycle between back-to-back frames.
REQ-016 Bit handshake SHALL be o_bit_valid && i_bit_ready; while o_bit_valid=1 and i_bit_ready=0, o_bit, o_sof and o_eof SHALL hold stable.
REQ-017 Running residue rem (0..2) SHALL clear to 0 on accept and update to (2*rem + o_bit) mod 3 on each payload-bit handshake.
REQ-018 Check bits SHALL be rem=0 -> 00, rem=1 -> 10, rem=2 -> 01 (i.e. (3-rem) mod 3), fixed at the final payload-bit handshake.
REQ-019 o_eof SHALL be 1 only in CHK0; o_sof only on payload MSB; o_bit_valid SHALL be 0 in IDLE.
REQ-020 i_data changes while not accepted SHALL have no effect; payload SHALL be captured only on accept.

Reset
REQ-021 With i_rst_n=0 at a rising edge, state SHALL become IDLE, rem 0, bit counter 0, shift register 0.
REQ-022 While i_rst_n=0, o_ready, o_bit, o_bit_valid, o_sof, o_eof SHALL all be 0.
REQ-023 Reset mid-frame SHALL discard the frame; the first cycle after release SHALL be IDLE with o_ready=1.

Structure
REQ-024 Package mod3_pkg SHALL hold the state enum type, the 2-bit residue type and the residue-to-check-bits function.
REQ-025 Sub-module mod3_residue_step (combinational: rem, bit -> next rem) SHALL be instantiated once.
REQ-026 Bit counter SHALL be $clog2(DATA_W) bits wide and wrap only via state transition.

Verification
REQ-027 i_data=8'h06, i_bit_ready=1 -> bits 0000011000, sof on bit 1, eof on bit 10; frame value 24.
REQ-028 i_data=8'h07 -> bits 0000011110, check 10; frame value 30.
REQ-029 i_data=8'h05 -> bits 0000010101, check 01; frame value 21; i_data=8'hFF -> check 00.
REQ-030 i_bit_ready=0 for 3 cycles during payload bit 4 -> o_bit held 3 cycles, frame bits unchanged.
REQ-031 Two payloads with i_valid held high -> second accepted on CHK0 handshake, its sof the next cycle, no gap.
REQ-032 i_rst_n=0 for one cycle during DATA -> all outputs 0 that cycle, o_ready=1 after release, next frame starts with sof and rem 0.
